// File: rtl/operand_feeder_pkg.sv
// operand_feeder_pkg: shared types for the operand feeder slice.
//   feeder_state_e : tile sequencer states (IDLE waits for a command, RUN streams K beats)
//   beat_flags_t   : per-beat markers carried alongside operand data
package operand_feeder_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } feeder_state_e;

  typedef struct packed {
    logic rst_acc;     // first beat of a tile
    logic stream_out;  // last beat of a tile
  } beat_flags_t;

endpackage

// File: rtl/operand_feeder_if.sv
// operand_feeder_if: bundles the command, operand-input and array-output
// handshakes of the operand feeder.
//   master : environment side (issues commands/operands, accepts array vectors)
//   slave  : feeder side
interface operand_feeder_if #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned KLEN_WIDTH = 16
);

  logic [KLEN_WIDTH-1:0]    cmd_k_len;
  logic                     cmd_vld;
  logic                     cmd_rdy;
  logic [IN_WIDTH*ROWS-1:0] a_data;
  logic                     a_vld;
  logic                     a_rdy;
  logic [IN_WIDTH*COLS-1:0] b_data;
  logic                     b_vld;
  logic                     b_rdy;
  logic [IN_WIDTH*ROWS-1:0] row_data_in;
  logic                     row_data_in_vld;
  logic                     row_data_in_rdy;
  logic [IN_WIDTH*COLS-1:0] col_data_in;
  logic                     col_data_in_vld;
  logic                     col_data_in_rdy;
  logic                     rst_accumulator_rdy;
  logic                     stream_out_rdy;
  logic                     busy;
  logic                     tile_done;

  modport master (
    output cmd_k_len, cmd_vld, a_data, a_vld, b_data, b_vld,
           row_data_in_rdy, col_data_in_rdy,
    input  cmd_rdy, a_rdy, b_rdy, row_data_in, row_data_in_vld,
           col_data_in, col_data_in_vld, rst_accumulator_rdy,
           stream_out_rdy, busy, tile_done
  );

  modport slave (
    input  cmd_k_len, cmd_vld, a_data, a_vld, b_data, b_vld,
           row_data_in_rdy, col_data_in_rdy,
    output cmd_rdy, a_rdy, b_rdy, row_data_in, row_data_in_vld,
           col_data_in, col_data_in_vld, rst_accumulator_rdy,
           stream_out_rdy, busy, tile_done
  );

endinterface

// File: rtl/operand_feeder_pipe_reg.sv
// pipe_reg: one-entry valid/ready register carrying operand data and beat flags.
//   clk, rst                      : clock, async active-high reset
//   in_vld/in_rdy/in_data/in_flags: upstream side
//   out_vld/out_rdy/out_data/out_flags: downstream side
// Contents are cleared whenever the entry empties, so flags read 0 while out_vld=0.
module pipe_reg
  import operand_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  input  beat_flags_t      in_flags,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output beat_flags_t      out_flags
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  beat_flags_t      flags_q, flags_d;

  always_comb begin
    in_rdy  = !vld_q || out_rdy;
    vld_d   = vld_q;
    data_d  = data_q;
    flags_d = flags_q;
    if (in_vld && in_rdy) begin
      vld_d   = 1'b1;
      data_d  = in_data;
      flags_d = in_flags;
    end else if (vld_q && out_rdy) begin
      vld_d   = 1'b0;
      data_d  = '0;
      flags_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign out_vld   = vld_q;
  assign out_data  = data_q;
  assign out_flags = flags_q;

endmodule

// File: rtl/operand_feeder.sv
// operand_feeder: accepts a tile command of K beats, pairs row/column operand
// beats and forwards them through a one-stage register to the systolic array,
// marking the first (rst_accumulator_rdy) and last (stream_out_rdy) beat.
//   clk, rst : clock, async active-high reset
//   bus      : operand_feeder_if slave (command, a/b operands, row/col outputs,
//              beat flags, busy, tile_done)
module operand_feeder
  import operand_feeder_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned KLEN_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  operand_feeder_if.slave     bus
);

  localparam int unsigned ROW_W = IN_WIDTH * ROWS;
  localparam int unsigned COL_W = IN_WIDTH * COLS;
  localparam int unsigned DW    = ROW_W + COL_W;
  localparam logic [KLEN_WIDTH-1:0] ONE = {{(KLEN_WIDTH-1){1'b0}}, 1'b1};

  feeder_state_e         state_q, state_d;
  logic [KLEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [KLEN_WIDTH-1:0] k_q, k_d;
  logic                  tile_done_q, tile_done_d;

  logic        pipe_in_vld, pipe_in_rdy, pipe_out_vld, pipe_out_rdy;
  logic        accept, last_beat;
  logic [DW-1:0] in_data, out_data;
  beat_flags_t in_flags, out_flags;

  always_comb begin
    pipe_in_vld  = (state_q == ST_RUN) && bus.a_vld && bus.b_vld;
    accept       = pipe_in_vld && pipe_in_rdy;
    pipe_out_rdy = bus.row_data_in_rdy && bus.col_data_in_rdy;
    last_beat    = (cnt_q == k_q - ONE);

    in_data             = {bus.a_data, bus.b_data};
    in_flags.rst_acc    = (cnt_q == '0);
    in_flags.stream_out = last_beat;

    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    // A tile ends either when its last beat drains downstream or on a K=0 command.
    tile_done_d = pipe_out_vld && pipe_out_rdy && out_flags.stream_out;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_vld) begin
          k_d   = bus.cmd_k_len;
          cnt_d = '0;
          if (bus.cmd_k_len != '0) begin
            state_d = ST_RUN;
          end else begin
            tile_done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      tile_done_q <= tile_done_d;
    end
  end

  pipe_reg #(
    .WIDTH (DW)
  ) u_pipe_reg (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (pipe_in_vld),
    .in_rdy    (pipe_in_rdy),
    .in_data   (in_data),
    .in_flags  (in_flags),
    .out_vld   (pipe_out_vld),
    .out_rdy   (pipe_out_rdy),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  assign bus.cmd_rdy             = (state_q == ST_IDLE);
  assign bus.a_rdy               = accept;
  assign bus.b_rdy               = accept;
  assign bus.row_data_in         = out_data[DW-1 -: ROW_W];
  assign bus.col_data_in         = out_data[COL_W-1:0];
  assign bus.row_data_in_vld     = pipe_out_vld;
  assign bus.col_data_in_vld     = pipe_out_vld;
  assign bus.rst_accumulator_rdy = out_flags.rst_acc;
  assign bus.stream_out_rdy      = out_flags.stream_out;
  assign bus.busy                = (state_q == ST_RUN) || pipe_out_vld;
  assign bus.tile_done           = tile_done_q;

endmodule

// File: tb/tb_operand_feeder.sv
// tb_operand_feeder: directed bench for operand_feeder. Inputs change 1 ns
// after each rising edge; outputs are checked on the falling edge.
module tb_operand_feeder;

  localparam int unsigned IN_WIDTH   = 8;
  localparam int unsigned ROWS       = 4;
  localparam int unsigned COLS       = 4;
  localparam int unsigned KLEN_WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  operand_feeder_if #(
    .IN_WIDTH   (IN_WIDTH),
    .ROWS       (ROWS),
    .COLS       (COLS),
    .KLEN_WIDTH (KLEN_WIDTH)
  ) bus ();

  operand_feeder #(
    .IN_WIDTH   (IN_WIDTH),
    .ROWS       (ROWS),
    .COLS       (COLS),
    .KLEN_WIDTH (KLEN_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic rf, input logic sf);
    chk({tag, ".row_vld"}, 32'(bus.row_data_in_vld), 32'd1);
    chk({tag, ".col_vld"}, 32'(bus.col_data_in_vld), 32'd1);
    chk({tag, ".row"}, bus.row_data_in, a);
    chk({tag, ".col"}, bus.col_data_in, b);
    chk({tag, ".rst_acc"}, 32'(bus.rst_accumulator_rdy), 32'(rf));
    chk({tag, ".stream"}, 32'(bus.stream_out_rdy), 32'(sf));
  endtask

  task automatic drive_idle();
    bus.cmd_k_len       = '0;
    bus.cmd_vld         = 1'b0;
    bus.a_data          = '0;
    bus.a_vld           = 1'b0;
    bus.b_data          = '0;
    bus.b_vld           = 1'b0;
    bus.row_data_in_rdy = 1'b1;
    bus.col_data_in_rdy = 1'b1;
  endtask

  task automatic set_ab(input logic [31:0] a, input logic [31:0] b);
    bus.a_data = a;
    bus.b_data = b;
    bus.a_vld  = 1'b1;
    bus.b_vld  = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    #2;
    chk("reset.row_vld", 32'(bus.row_data_in_vld), 32'd0);
    chk("reset.row", bus.row_data_in, 32'd0);
    chk("reset.col", bus.col_data_in, 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.tile_done", 32'(bus.tile_done), 32'd0);
    chk("reset.cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    nxt();
    rst = 1'b0;

    // K=3, continuous input and output
    nxt();
    bus.cmd_k_len = 16'd3;
    bus.cmd_vld   = 1'b1;
    set_ab(32'hA0A0_0001, 32'hB0B0_0001);
    settle();
    chk("k3.cmd_rdy_idle", 32'(bus.cmd_rdy), 32'd1);
    chk("k3.a_rdy_idle", 32'(bus.a_rdy), 32'd0);
    nxt();
    bus.cmd_vld = 1'b0;
    settle();
    chk("k3.cmd_rdy_run", 32'(bus.cmd_rdy), 32'd0);
    chk("k3.a_rdy_run", 32'(bus.a_rdy), 32'd1);
    chk("k3.b_rdy_run", 32'(bus.b_rdy), 32'd1);
    chk("k3.busy", 32'(bus.busy), 32'd1);
    nxt();
    set_ab(32'hA0A0_0002, 32'hB0B0_0002);
    settle();
    chk_beat("k3.beat0", 32'hA0A0_0001, 32'hB0B0_0001, 1'b1, 1'b0);
    nxt();
    set_ab(32'hA0A0_0003, 32'hB0B0_0003);
    settle();
    chk_beat("k3.beat1", 32'hA0A0_0002, 32'hB0B0_0002, 1'b0, 1'b0);
    nxt();
    bus.a_vld = 1'b0;
    bus.b_vld = 1'b0;
    settle();
    chk_beat("k3.beat2", 32'hA0A0_0003, 32'hB0B0_0003, 1'b0, 1'b1);
    chk("k3.cmd_rdy_after", 32'(bus.cmd_rdy), 32'd1);
    chk("k3.tile_done_early", 32'(bus.tile_done), 32'd0);
    nxt();
    settle();
    chk("k3.tile_done", 32'(bus.tile_done), 32'd1);
    chk("k3.vld_drained", 32'(bus.row_data_in_vld), 32'd0);
    chk("k3.flags_drained", {30'd0, bus.rst_accumulator_rdy, bus.stream_out_rdy}, 32'd0);
    chk("k3.busy_drained", 32'(bus.busy), 32'd0);
    nxt();
    settle();
    chk("k3.tile_done_pulse", 32'(bus.tile_done), 32'd0);

    // K=1: single beat carries both flags
    nxt();
    bus.cmd_k_len = 16'd1;
    bus.cmd_vld   = 1'b1;
    set_ab(32'hA1A1_0005, 32'hB1B1_0005);
    nxt();
    bus.cmd_vld = 1'b0;
    settle();
    chk("k1.a_rdy", 32'(bus.a_rdy), 32'd1);
    nxt();
    bus.a_vld = 1'b0;
    bus.b_vld = 1'b0;
    settle();
    chk_beat("k1.beat0", 32'hA1A1_0005, 32'hB1B1_0005, 1'b1, 1'b1);
    nxt();
    settle();
    chk("k1.tile_done", 32'(bus.tile_done), 32'd1);
    chk("k1.vld_drained", 32'(bus.row_data_in_vld), 32'd0);

    // K=0: no beats, tile_done one cycle after the command
    nxt();
    bus.cmd_k_len = 16'd0;
    bus.cmd_vld   = 1'b1;
    settle();
    chk("k0.tile_done_early", 32'(bus.tile_done), 32'd0);
    nxt();
    bus.cmd_vld = 1'b0;
    settle();
    chk("k0.tile_done", 32'(bus.tile_done), 32'd1);
    chk("k0.no_beat", 32'(bus.row_data_in_vld), 32'd0);
    chk("k0.cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("k0.busy", 32'(bus.busy), 32'd0);
    nxt();
    settle();
    chk("k0.tile_done_pulse", 32'(bus.tile_done), 32'd0);

    // K=4 with a 5-cycle column-side stall on the second beat
    nxt();
    bus.cmd_k_len = 16'd4;
    bus.cmd_vld   = 1'b1;
    set_ab(32'hD0D0_0000, 32'hE0E0_0000);
    nxt();
    bus.cmd_vld = 1'b0;
    nxt();
    set_ab(32'hD0D0_0001, 32'hE0E0_0001);
    settle();
    chk_beat("k4.beat0", 32'hD0D0_0000, 32'hE0E0_0000, 1'b1, 1'b0);
    nxt();
    set_ab(32'hD0D0_0002, 32'hE0E0_0002);
    bus.col_data_in_rdy = 1'b0;
    settle();
    chk_beat("k4.stall_first", 32'hD0D0_0001, 32'hE0E0_0001, 1'b0, 1'b0);
    chk("k4.stall_a_rdy", 32'(bus.a_rdy), 32'd0);
    chk("k4.stall_b_rdy", 32'(bus.b_rdy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      settle();
      chk_beat("k4.stall_hold", 32'hD0D0_0001, 32'hE0E0_0001, 1'b0, 1'b0);
      chk("k4.stall_hold_a_rdy", 32'(bus.a_rdy), 32'd0);
    end
    nxt();
    bus.col_data_in_rdy = 1'b1;
    settle();
    chk_beat("k4.release", 32'hD0D0_0001, 32'hE0E0_0001, 1'b0, 1'b0);
    chk("k4.release_a_rdy", 32'(bus.a_rdy), 32'd1);
    nxt();
    set_ab(32'hD0D0_0003, 32'hE0E0_0003);
    settle();
    chk_beat("k4.beat2", 32'hD0D0_0002, 32'hE0E0_0002, 1'b0, 1'b0);
    nxt();
    bus.a_vld = 1'b0;
    bus.b_vld = 1'b0;
    settle();
    chk_beat("k4.beat3", 32'hD0D0_0003, 32'hE0E0_0003, 1'b0, 1'b1);
    nxt();
    settle();
    chk("k4.tile_done", 32'(bus.tile_done), 32'd1);
    chk("k4.vld_drained", 32'(bus.row_data_in_vld), 32'd0);

    // back-to-back K=2 tiles
    nxt();
    bus.cmd_k_len = 16'd2;
    bus.cmd_vld   = 1'b1;
    set_ab(32'h1111_0000, 32'h2222_0000);
    nxt();
    bus.cmd_vld = 1'b0;
    nxt();
    set_ab(32'h1111_0001, 32'h2222_0001);
    settle();
    chk_beat("b2b.beat0", 32'h1111_0000, 32'h2222_0000, 1'b1, 1'b0);
    nxt();
    bus.cmd_vld = 1'b1;
    set_ab(32'h1111_0002, 32'h2222_0002);
    settle();
    chk_beat("b2b.beat1", 32'h1111_0001, 32'h2222_0001, 1'b0, 1'b1);
    chk("b2b.cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("b2b.a_rdy_idle", 32'(bus.a_rdy), 32'd0);
    nxt();
    bus.cmd_vld = 1'b0;
    settle();
    chk("b2b.tile_done1", 32'(bus.tile_done), 32'd1);
    chk("b2b.second_cmd_run", 32'(bus.cmd_rdy), 32'd0);
    chk("b2b.a_rdy_run", 32'(bus.a_rdy), 32'd1);
    nxt();
    set_ab(32'h1111_0003, 32'h2222_0003);
    settle();
    chk_beat("b2b.beat2", 32'h1111_0002, 32'h2222_0002, 1'b1, 1'b0);
    chk("b2b.tile_done_pulse", 32'(bus.tile_done), 32'd0);
    nxt();
    bus.a_vld = 1'b0;
    bus.b_vld = 1'b0;
    settle();
    chk_beat("b2b.beat3", 32'h1111_0003, 32'h2222_0003, 1'b0, 1'b1);
    nxt();
    settle();
    chk("b2b.tile_done2", 32'(bus.tile_done), 32'd1);

    // b_vld toggling with a_vld held high
    nxt();
    bus.cmd_k_len = 16'd2;
    bus.cmd_vld   = 1'b1;
    nxt();
    bus.cmd_vld = 1'b0;
    set_ab(32'h3333_0000, 32'h4444_0000);
    settle();
    chk("tog.a_rdy0", 32'(bus.a_rdy), 32'd1);
    nxt();
    bus.a_data = 32'h3333_0001;
    bus.b_vld  = 1'b0;
    settle();
    chk("tog.a_rdy_no_b", 32'(bus.a_rdy), 32'd0);
    chk("tog.b_rdy_no_b", 32'(bus.b_rdy), 32'd0);
    chk_beat("tog.beat0", 32'h3333_0000, 32'h4444_0000, 1'b1, 1'b0);
    nxt();
    bus.b_data = 32'h4444_0001;
    bus.b_vld  = 1'b1;
    settle();
    chk("tog.gap", 32'(bus.row_data_in_vld), 32'd0);
    chk("tog.a_rdy1", 32'(bus.a_rdy), 32'd1);
    nxt();
    bus.a_vld = 1'b0;
    bus.b_vld = 1'b0;
    settle();
    chk_beat("tog.beat1", 32'h3333_0001, 32'h4444_0001, 1'b0, 1'b1);
    nxt();
    settle();
    chk("tog.tile_done", 32'(bus.tile_done), 32'd1);

    // reset after beat 2 of a K=5 tile
    nxt();
    bus.cmd_k_len = 16'd5;
    bus.cmd_vld   = 1'b1;
    nxt();
    bus.cmd_vld = 1'b0;
    set_ab(32'h5555_0000, 32'h6666_0000);
    nxt();
    set_ab(32'h5555_0001, 32'h6666_0001);
    nxt();
    bus.a_vld = 1'b0;
    bus.b_vld = 1'b0;
    settle();
    chk_beat("rst5.beat1", 32'h5555_0001, 32'h6666_0001, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst5.row_vld", 32'(bus.row_data_in_vld), 32'd0);
    chk("rst5.row", bus.row_data_in, 32'd0);
    chk("rst5.col", bus.col_data_in, 32'd0);
    chk("rst5.flags", {30'd0, bus.rst_accumulator_rdy, bus.stream_out_rdy}, 32'd0);
    chk("rst5.busy", 32'(bus.busy), 32'd0);
    chk("rst5.cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    nxt();
    rst = 1'b0;
    settle();
    chk("rst5.no_tile_done", 32'(bus.tile_done), 32'd0);
    nxt();
    bus.cmd_k_len = 16'd2;
    bus.cmd_vld   = 1'b1;
    nxt();
    bus.cmd_vld = 1'b0;
    set_ab(32'h7777_0000, 32'h8888_0000);
    nxt();
    set_ab(32'h7777_0001, 32'h8888_0001);
    settle();
    chk_beat("post.beat0", 32'h7777_0000, 32'h8888_0000, 1'b1, 1'b0);
    nxt();
    bus.a_vld = 1'b0;
    bus.b_vld = 1'b0;
    settle();
    chk_beat("post.beat1", 32'h7777_0001, 32'h8888_0001, 1'b0, 1'b1);
    nxt();
    settle();
    chk("post.tile_done", 32'(bus.tile_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
